// File: rtl/minisrc_control_unit_pkg.sv
// Shared definitions for the Mini SRC control sequencer: state encoding,
// opcode map, ALU operation codes and the control word driven to the datapath.
package minisrc_ctrl_pkg;

    // T3..T7 are consecutive so the execute phase can advance with state + 1.
    typedef enum logic [3:0] {
        S_RESET = 4'd0, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110, OP_SHL  = 5'b00111, OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001, OP_AND  = 5'b01010, OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011, ALU_AND = 5'b01010, ALU_OR = 5'b01011;

    typedef struct packed {
        logic pc_in, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, outport_in, inc_pc;
        logic pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, inport_out, c_out;
        logic read, write;
        logic gra, grb, grc, rin, rout, ba_out;
        logic con_in;
        logic [4:0] alu;
    } ctrl_word_t;

    // Illegal opcodes: jal and the 111xx block.
    function automatic logic is_illegal(input logic [4:0] op);
        return (op == OP_JAL) || (op[4:2] == 3'b111);
    endfunction

    // Final execute state of each instruction; T2 for anything with no execute phase.
    function automatic state_t last_state(input logic [4:0] op);
        state_t s;
        case (op) inside
            [OP_ADD:OP_ORI], OP_LDI:                s = S_T5;
            OP_NEG, OP_NOT:                         s = S_T4;
            OP_MUL, OP_DIV, OP_BR:                  s = S_T6;
            OP_LD, OP_ST:                           s = S_T7;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: s = S_T3;
            default:                                s = S_T2;
        endcase
        return s;
    endfunction

    function automatic logic [4:0] imm_alu(input logic [4:0] op);
        logic [4:0] a;
        case (op)
            OP_ANDI: a = ALU_AND;
            OP_ORI:  a = ALU_OR;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/minisrc_control_unit_if.sv
// Control-side bundle between the sequencer (master) and the Mini SRC datapath (slave).
// MINISRC_MEM_WAIT_EN adds the mem_ready handshake from memory.
interface minisrc_control_unit_if;
    logic [31:0] IR_Data;
    logic        CON_out;
    logic        stop;
`ifdef MINISRC_MEM_WAIT_EN
    logic        mem_ready;
`endif
    logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC;
    logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
    logic Read, Write;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic CON_in;
    logic [4:0] alu_instruction_bits;
    logic run;

    modport master (
`ifdef MINISRC_MEM_WAIT_EN
        input  mem_ready,
`endif
        input  IR_Data, CON_out, stop,
        output PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
        output PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
        output Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, CON_in,
        output alu_instruction_bits, run
    );

    modport slave (
`ifdef MINISRC_MEM_WAIT_EN
        output mem_ready,
`endif
        output IR_Data, CON_out, stop,
        input  PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
        input  PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
        input  Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, CON_in,
        input  alu_instruction_bits, run
    );
endinterface

// File: rtl/minisrc_control_unit_decode.sv
// Moore decode: (state, opcode, CON_out) -> datapath control word.
// CON_out only gates the branch-taken PC load in T6.
module minisrc_ctrl_decode
    import minisrc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] opcode,
    input  logic       con_out,
    output ctrl_word_t cw
);

    // Control strobes for the current state; anything not named stays low.
    always_comb begin
        cw = '0;
        case (state)
            S_T0: begin cw.pc_out = 1'b1; cw.mar_in = 1'b1; cw.inc_pc = 1'b1; cw.z_in = 1'b1; end
            S_T1: begin cw.zlow_out = 1'b1; cw.pc_in = 1'b1; cw.read = 1'b1; cw.mdr_in = 1'b1; end
            S_T2: begin cw.mdr_out = 1'b1; cw.ir_in = 1'b1; end
            S_T3: begin
                case (opcode) inside
                    [OP_ADD:OP_ORI]:     begin cw.grb = 1'b1; cw.rout = 1'b1; cw.y_in = 1'b1; end
                    OP_NEG, OP_NOT:      begin cw.grb = 1'b1; cw.rout = 1'b1; cw.z_in = 1'b1; cw.alu = opcode; end
                    OP_MUL, OP_DIV:      begin cw.gra = 1'b1; cw.rout = 1'b1; cw.y_in = 1'b1; end
                    OP_LD, OP_LDI, OP_ST: begin cw.grb = 1'b1; cw.ba_out = 1'b1; cw.y_in = 1'b1; end
                    OP_BR:   begin cw.gra = 1'b1; cw.rout = 1'b1; cw.con_in = 1'b1; end
                    OP_JR:   begin cw.gra = 1'b1; cw.rout = 1'b1; cw.pc_in = 1'b1; end
                    OP_IN:   begin cw.inport_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
                    OP_OUT:  begin cw.gra = 1'b1; cw.rout = 1'b1; cw.outport_in = 1'b1; end
                    OP_MFHI: begin cw.hi_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
                    OP_MFLO: begin cw.lo_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (opcode) inside
                    [OP_ADD:OP_OR]:      begin cw.grc = 1'b1; cw.rout = 1'b1; cw.z_in = 1'b1; cw.alu = opcode; end
                    [OP_ADDI:OP_ORI]:    begin cw.c_out = 1'b1; cw.z_in = 1'b1; cw.alu = imm_alu(opcode); end
                    OP_NEG, OP_NOT:      begin cw.zlow_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
                    OP_MUL, OP_DIV:      begin cw.grb = 1'b1; cw.rout = 1'b1; cw.z_in = 1'b1; cw.alu = opcode; end
                    OP_LD, OP_LDI, OP_ST: begin cw.c_out = 1'b1; cw.z_in = 1'b1; cw.alu = ALU_ADD; end
                    OP_BR:               begin cw.pc_out = 1'b1; cw.y_in = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (opcode) inside
                    [OP_ADD:OP_ORI], OP_LDI: begin cw.zlow_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
                    OP_MUL, OP_DIV:      begin cw.zlow_out = 1'b1; cw.lo_in = 1'b1; end
                    OP_LD, OP_ST:        begin cw.zlow_out = 1'b1; cw.mar_in = 1'b1; end
                    OP_BR:               begin cw.c_out = 1'b1; cw.z_in = 1'b1; cw.alu = ALU_ADD; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (opcode)
                    OP_MUL, OP_DIV: begin cw.zhigh_out = 1'b1; cw.hi_in = 1'b1; end
                    OP_LD:          begin cw.read = 1'b1; cw.mdr_in = 1'b1; end
                    OP_ST:          begin cw.gra = 1'b1; cw.rout = 1'b1; cw.mdr_in = 1'b1; end
                    OP_BR:          begin cw.zlow_out = con_out; cw.pc_in = con_out; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (opcode)
                    OP_LD:   begin cw.mdr_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
                    OP_ST:   cw.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/minisrc_control_unit.sv
// Hardwired Moore sequencer for the Mini SRC datapath: fetch T0-T2, execute T3-T7.
// Optional build macro MINISRC_MEM_WAIT_EN stretches memory states until mem_ready.
//
//   state | meaning
//   RESET | held by clr, all strobes low
//   T0-T2 | instruction fetch
//   T3-T7 | execute, length depends on opcode
//   HALT  | stopped, only clr leaves
module minisrc_control_unit
    import minisrc_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALTS = 1'b1
) (
    input logic clk,
    input logic clr,
    minisrc_control_unit_if.master bus
);

    state_t     state, next_state, boundary;
    logic [4:0] opcode;
    logic       mem_hold;
    logic       run_q;
    ctrl_word_t cw;
    logic       unused_ir;

    assign opcode    = bus.IR_Data[31:27];
    assign unused_ir = ^bus.IR_Data[26:0];

    // Next state: fetch, opcode dispatch in T2, stop check at the instruction's last state.
    always_comb begin
        boundary = bus.stop ? S_HALT : S_T0;
        mem_hold = 1'b0;
`ifdef MINISRC_MEM_WAIT_EN
        mem_hold = !bus.mem_ready && ((state == S_T1) ||
                                      (state == S_T6 && opcode == OP_LD) ||
                                      (state == S_T7 && opcode == OP_ST));
`endif
        next_state = state;
        case (state)
            S_RESET: next_state = S_T0;
            S_T0:    next_state = S_T1;
            S_T1:    next_state = S_T2;
            S_T2: begin
                if (opcode == OP_HALT)      next_state = S_HALT;
                else if (is_illegal(opcode)) next_state = ILLEGAL_HALTS ? S_HALT : boundary;
                else if (opcode == OP_NOP)  next_state = boundary;
                else                        next_state = S_T3;
            end
            S_T3, S_T4, S_T5, S_T6, S_T7:
                next_state = (state == last_state(opcode)) ? boundary : state_t'(state + 4'd1);
            S_HALT:  next_state = S_HALT;
            default: next_state = S_HALT;
        endcase
        if (mem_hold) next_state = state;
    end

    // State register and registered run flag; clr drops both immediately.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_RESET;
            run_q <= 1'b0;
        end else begin
            state <= next_state;
            run_q <= (next_state != S_RESET) && (next_state != S_HALT);
        end
    end

    minisrc_ctrl_decode u_decode (
        .state   (state),
        .opcode  (opcode),
        .con_out (bus.CON_out),
        .cw      (cw)
    );

    assign bus.PC_in      = cw.pc_in;
    assign bus.IR_in      = cw.ir_in;
    assign bus.Y_in       = cw.y_in;
    assign bus.Z_in       = cw.z_in;
    assign bus.HI_in      = cw.hi_in;
    assign bus.LO_in      = cw.lo_in;
    assign bus.MAR_in     = cw.mar_in;
    assign bus.MDR_in     = cw.mdr_in;
    assign bus.OutPort_in = cw.outport_in;
    assign bus.IncPC      = cw.inc_pc;
    assign bus.PC_out     = cw.pc_out;
    assign bus.Zhigh_out  = cw.zhigh_out;
    assign bus.Zlow_out   = cw.zlow_out;
    assign bus.HI_out     = cw.hi_out;
    assign bus.LO_out     = cw.lo_out;
    assign bus.MDR_out    = cw.mdr_out;
    assign bus.InPort_out = cw.inport_out;
    assign bus.C_out      = cw.c_out;
    assign bus.Read       = cw.read;
    assign bus.Write      = cw.write;
    assign bus.Gra        = cw.gra;
    assign bus.Grb        = cw.grb;
    assign bus.Grc        = cw.grc;
    assign bus.Rin        = cw.rin;
    assign bus.Rout       = cw.rout;
    assign bus.BAout      = cw.ba_out;
    assign bus.CON_in     = cw.con_in;
    assign bus.alu_instruction_bits = cw.alu;
    assign bus.run        = run_q;

endmodule

// File: tb/tb_minisrc_control_unit.sv
// Bench for minisrc_control_unit: per-cycle vector table plus hand-written
// sequences for clr, halt, illegal opcodes and (with MINISRC_MEM_WAIT_EN) memory wait.
module tb_minisrc_control_unit;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    minisrc_control_unit_if dif();
    minisrc_control_unit_if nif();

    minisrc_control_unit #(.ILLEGAL_HALTS(1'b1)) dut    (.clk(clk), .clr(clr), .bus(dif));
    minisrc_control_unit #(.ILLEGAL_HALTS(1'b0)) dut_nh (.clk(clk), .clr(clr), .bus(nif));

    localparam logic [26:0] M_PC_IN  = 27'h1 << 0,  M_IR_IN   = 27'h1 << 1,  M_Y_IN    = 27'h1 << 2;
    localparam logic [26:0] M_Z_IN   = 27'h1 << 3,  M_HI_IN   = 27'h1 << 4,  M_LO_IN   = 27'h1 << 5;
    localparam logic [26:0] M_MAR_IN = 27'h1 << 6,  M_MDR_IN  = 27'h1 << 7,  M_OUTP_IN = 27'h1 << 8;
    localparam logic [26:0] M_INC_PC = 27'h1 << 9,  M_PC_OUT  = 27'h1 << 10, M_ZHIGH   = 27'h1 << 11;
    localparam logic [26:0] M_ZLOW   = 27'h1 << 12, M_HI_OUT  = 27'h1 << 13, M_LO_OUT  = 27'h1 << 14;
    localparam logic [26:0] M_MDR_OUT= 27'h1 << 15, M_INP_OUT = 27'h1 << 16, M_C_OUT   = 27'h1 << 17;
    localparam logic [26:0] M_READ   = 27'h1 << 18, M_WRITE   = 27'h1 << 19, M_GRA     = 27'h1 << 20;
    localparam logic [26:0] M_GRB    = 27'h1 << 21, M_GRC     = 27'h1 << 22, M_RIN     = 27'h1 << 23;
    localparam logic [26:0] M_ROUT   = 27'h1 << 24, M_BA_OUT  = 27'h1 << 25, M_CON_IN  = 27'h1 << 26;

    localparam logic [26:0] F0 = M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN;
    localparam logic [26:0] F1 = M_ZLOW | M_PC_IN | M_READ | M_MDR_IN;
    localparam logic [26:0] F2 = M_MDR_OUT | M_IR_IN;

    localparam logic [31:0] I_ADD  = 32'h19A28000, I_BR   = 32'h9B100019, I_LD  = 32'h00800055;
    localparam logic [31:0] I_NEG  = 32'h88000000, I_MUL  = 32'h80000000, I_ST  = 32'h10000000;
    localparam logic [31:0] I_ANDI = 32'h68000000, I_NOP  = 32'hD0000000, I_JR  = 32'hA0000000;
    localparam logic [31:0] I_MFHI = 32'hC0000000, I_HALT = 32'hD8000000, I_ILL = 32'hF8000000;

    typedef struct {
        logic [31:0] ir;
        logic        con;
        logic        stop;
        logic [26:0] strb;
        logic [4:0]  alu;
        logic        run;
    } vec_t;

    vec_t        tbl[$];
    logic [32:0] sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [32:0] snap(input bit sel);
        logic [32:0] v;
        if (!sel)
            v = {dif.CON_in, dif.BAout, dif.Rout, dif.Rin, dif.Grc, dif.Grb, dif.Gra, dif.Write,
                 dif.Read, dif.C_out, dif.InPort_out, dif.MDR_out, dif.LO_out, dif.HI_out,
                 dif.Zlow_out, dif.Zhigh_out, dif.PC_out, dif.IncPC, dif.OutPort_in, dif.MDR_in,
                 dif.MAR_in, dif.LO_in, dif.HI_in, dif.Z_in, dif.Y_in, dif.IR_in, dif.PC_in,
                 dif.alu_instruction_bits, dif.run};
        else
            v = {nif.CON_in, nif.BAout, nif.Rout, nif.Rin, nif.Grc, nif.Grb, nif.Gra, nif.Write,
                 nif.Read, nif.C_out, nif.InPort_out, nif.MDR_out, nif.LO_out, nif.HI_out,
                 nif.Zlow_out, nif.Zhigh_out, nif.PC_out, nif.IncPC, nif.OutPort_in, nif.MDR_in,
                 nif.MAR_in, nif.LO_in, nif.HI_in, nif.Z_in, nif.Y_in, nif.IR_in, nif.PC_in,
                 nif.alu_instruction_bits, nif.run};
        return v;
    endfunction

    task automatic chk(input string tag, input int idx, input logic [32:0] got, input logic [32:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got strb=%07h alu=%05b run=%b, want strb=%07h alu=%05b run=%b",
                     tag, idx, got[32:6], got[5:1], got[0], exp[32:6], exp[5:1], exp[0]);
        end
    endtask

    // One clock cycle: drive inputs just after posedge, score at negedge, return just after next posedge.
    task automatic step(input bit sel, input string tag, input int idx, input logic [31:0] ir,
                        input logic con, input logic stp, input logic mr, input logic [32:0] exp);
        dif.IR_Data = ir; dif.CON_out = con; dif.stop = stp;
        nif.IR_Data = ir; nif.CON_out = con; nif.stop = stp;
`ifdef MINISRC_MEM_WAIT_EN
        dif.mem_ready = mr; nif.mem_ready = mr;
`else
        if (mr !== 1'b1) $display("note: mem_ready stimulus ignored in this build");
`endif
        sb.push_back(exp);
        @(negedge clk);
        chk(tag, idx, snap(sel), sb.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr(input bit sel, input string tag);
        clr = 1'b1;
        #1;
        chk(tag, 0, snap(sel), 33'd0);
        clr = 1'b0;
    endtask

    task automatic fetch_steps(input bit sel, input string tag, input logic [31:0] ir);
        step(sel, tag, 0, ir, 1'b0, 1'b0, 1'b1, {F0, 5'd0, 1'b1});
        step(sel, tag, 1, ir, 1'b0, 1'b0, 1'b1, {F1, 5'd0, 1'b1});
        step(sel, tag, 2, ir, 1'b0, 1'b0, 1'b1, {F2, 5'd0, 1'b1});
    endtask

    task automatic row(input logic [31:0] ir, input logic con, input logic stp,
                       input logic [26:0] s, input logic [4:0] a, input logic r);
        vec_t v;
        v.ir = ir; v.con = con; v.stop = stp; v.strb = s; v.alu = a; v.run = r;
        tbl.push_back(v);
    endtask

    task automatic fetch_rows(input logic [31:0] ir, input logic con, input logic stp);
        row(ir, con, stp, F0, 5'd0, 1'b1);
        row(ir, con, stp, F1, 5'd0, 1'b1);
        row(ir, con, stp, F2, 5'd0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Back-to-back instruction stream, one row per clock after clr release.
        row(I_ADD, 0, 0, 27'd0, 5'd0, 1'b0);
        fetch_rows(I_ADD, 0, 0);
        row(I_ADD, 0, 0, M_GRB | M_ROUT | M_Y_IN, 5'd0, 1'b1);
        row(I_ADD, 0, 0, M_GRC | M_ROUT | M_Z_IN, 5'b00011, 1'b1);
        row(I_ADD, 0, 0, M_ZLOW | M_GRA | M_RIN, 5'd0, 1'b1);
        for (int c = 1; c >= 0; c--) begin
            fetch_rows(I_BR, c[0], 0);
            row(I_BR, c[0], 0, M_GRA | M_ROUT | M_CON_IN, 5'd0, 1'b1);
            row(I_BR, c[0], 0, M_PC_OUT | M_Y_IN, 5'd0, 1'b1);
            row(I_BR, c[0], 0, M_C_OUT | M_Z_IN, 5'b00011, 1'b1);
            row(I_BR, c[0], 0, c[0] ? (M_ZLOW | M_PC_IN) : 27'd0, 5'd0, 1'b1);
        end
        fetch_rows(I_LD, 0, 0);
        row(I_LD, 0, 0, M_GRB | M_BA_OUT | M_Y_IN, 5'd0, 1'b1);
        row(I_LD, 0, 0, M_C_OUT | M_Z_IN, 5'b00011, 1'b1);
        row(I_LD, 0, 0, M_ZLOW | M_MAR_IN, 5'd0, 1'b1);
        row(I_LD, 0, 0, M_READ | M_MDR_IN, 5'd0, 1'b1);
        row(I_LD, 0, 0, M_MDR_OUT | M_GRA | M_RIN, 5'd0, 1'b1);
        fetch_rows(I_NEG, 0, 0);
        row(I_NEG, 0, 0, M_GRB | M_ROUT | M_Z_IN, 5'b10001, 1'b1);
        row(I_NEG, 0, 0, M_ZLOW | M_GRA | M_RIN, 5'd0, 1'b1);
        fetch_rows(I_MUL, 0, 0);
        row(I_MUL, 0, 0, M_GRA | M_ROUT | M_Y_IN, 5'd0, 1'b1);
        row(I_MUL, 0, 0, M_GRB | M_ROUT | M_Z_IN, 5'b10000, 1'b1);
        row(I_MUL, 0, 0, M_ZLOW | M_LO_IN, 5'd0, 1'b1);
        row(I_MUL, 0, 0, M_ZHIGH | M_HI_IN, 5'd0, 1'b1);
        fetch_rows(I_ST, 0, 0);
        row(I_ST, 0, 0, M_GRB | M_BA_OUT | M_Y_IN, 5'd0, 1'b1);
        row(I_ST, 0, 0, M_C_OUT | M_Z_IN, 5'b00011, 1'b1);
        row(I_ST, 0, 0, M_ZLOW | M_MAR_IN, 5'd0, 1'b1);
        row(I_ST, 0, 0, M_GRA | M_ROUT | M_MDR_IN, 5'd0, 1'b1);
        row(I_ST, 0, 0, M_WRITE, 5'd0, 1'b1);
        fetch_rows(I_ANDI, 0, 0);
        row(I_ANDI, 0, 0, M_GRB | M_ROUT | M_Y_IN, 5'd0, 1'b1);
        row(I_ANDI, 0, 0, M_C_OUT | M_Z_IN, 5'b01010, 1'b1);
        row(I_ANDI, 0, 0, M_ZLOW | M_GRA | M_RIN, 5'd0, 1'b1);
        fetch_rows(I_NOP, 0, 0);
        fetch_rows(I_JR, 0, 0);
        row(I_JR, 0, 0, M_GRA | M_ROUT | M_PC_IN, 5'd0, 1'b1);
        fetch_rows(I_MFHI, 0, 0);
        row(I_MFHI, 0, 0, M_HI_OUT | M_GRA | M_RIN, 5'd0, 1'b1);
        // stop held for a whole add: only the final state may act on it
        fetch_rows(I_ADD, 0, 1);
        row(I_ADD, 0, 1, M_GRB | M_ROUT | M_Y_IN, 5'd0, 1'b1);
        row(I_ADD, 0, 1, M_GRC | M_ROUT | M_Z_IN, 5'b00011, 1'b1);
        row(I_ADD, 0, 1, M_ZLOW | M_GRA | M_RIN, 5'd0, 1'b1);
        for (int k = 0; k < 3; k++) row(I_NOP, 0, 0, 27'd0, 5'd0, 1'b0);

        clr = 1'b1;
        dif.IR_Data = I_NOP; dif.CON_out = 1'b0; dif.stop = 1'b0;
        nif.IR_Data = I_NOP; nif.CON_out = 1'b0; nif.stop = 1'b0;
`ifdef MINISRC_MEM_WAIT_EN
        dif.mem_ready = 1'b1; nif.mem_ready = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 0, snap(0), 33'd0);
        clr = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            step(0, "tbl", i, tbl[i].ir, tbl[i].con, tbl[i].stop, 1'b1,
                 {tbl[i].strb, tbl[i].alu, tbl[i].run});

        // halt instruction parks in HALT until clr
        pulse_clr(0, "clr_halt");
        step(0, "halt", 0, I_HALT, 1'b0, 1'b0, 1'b1, 33'd0);
        fetch_steps(0, "halt_fetch", I_HALT);
        for (int k = 0; k < 10; k++) step(0, "halt_idle", k, I_HALT, 1'b0, 1'b0, 1'b1, 33'd0);
        pulse_clr(0, "clr_resume");
        step(0, "resume", 0, I_ADD, 1'b0, 1'b0, 1'b1, 33'd0);

        // clr during T4 of add
        step(0, "abort", 0, I_ADD, 1'b0, 1'b0, 1'b1, {F0, 5'd0, 1'b1});
        step(0, "abort", 1, I_ADD, 1'b0, 1'b0, 1'b1, {F1, 5'd0, 1'b1});
        step(0, "abort", 2, I_ADD, 1'b0, 1'b0, 1'b1, {F2, 5'd0, 1'b1});
        step(0, "abort", 3, I_ADD, 1'b0, 1'b0, 1'b1, {M_GRB | M_ROUT | M_Y_IN, 5'd0, 1'b1});
        chk("abort_t4", 0, snap(0), {M_GRC | M_ROUT | M_Z_IN, 5'b00011, 1'b1});
        pulse_clr(0, "abort_clr");
        step(0, "abort_after", 0, I_ADD, 1'b0, 1'b0, 1'b1, 33'd0);
        step(0, "abort_after", 1, I_ADD, 1'b0, 1'b0, 1'b1, {F0, 5'd0, 1'b1});

        // illegal opcode: halts with ILLEGAL_HALTS=1, treated as nop with 0
        pulse_clr(0, "ill_clr");
        step(0, "ill_h", 0, I_ILL, 1'b0, 1'b0, 1'b1, 33'd0);
        fetch_steps(0, "ill_h_fetch", I_ILL);
        step(0, "ill_h", 1, I_ILL, 1'b0, 1'b0, 1'b1, 33'd0);
        pulse_clr(1, "ill_nh_clr");
        step(1, "ill_nh", 0, I_ILL, 1'b0, 1'b0, 1'b1, 33'd0);
        fetch_steps(1, "ill_nh_fetch", I_ILL);
        step(1, "ill_nh", 1, I_ILL, 1'b0, 1'b0, 1'b1, {F0, 5'd0, 1'b1});

`ifdef MINISRC_MEM_WAIT_EN
        // memory not ready for three cycles in T1
        pulse_clr(0, "mw_clr");
        step(0, "mw", 0, I_ADD, 1'b0, 1'b0, 1'b1, 33'd0);
        step(0, "mw", 1, I_ADD, 1'b0, 1'b0, 1'b1, {F0, 5'd0, 1'b1});
        for (int k = 0; k < 3; k++) step(0, "mw_wait", k, I_ADD, 1'b0, 1'b0, 1'b0, {F1, 5'd0, 1'b1});
        step(0, "mw", 2, I_ADD, 1'b0, 1'b0, 1'b1, {F1, 5'd0, 1'b1});
        step(0, "mw", 3, I_ADD, 1'b0, 1'b0, 1'b1, {F2, 5'd0, 1'b1});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
